// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // Signed overflow from the operand sign bits captured at accept and the result MSB.
  function automatic logic ovf_calc(input logic mode, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    if (mode == MODE_ADD) return (a_msb == b_msb) && (r_msb != a_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational ripple of DIGIT full add/subtract cells.
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [DIGIT-1:0] d,
  output logic             cout
);

  always_comb begin
    logic c;
    c = cin;
    d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a[i] ^ b[i] ^ c;
      if (mode == MODE_ADD) c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      else                  c = (~a[i] & b[i]) | (~a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract with start/done handshake, final borrow/carry and
// signed overflow. Processes DIGIT bits per cycle, WIDTH/DIGIT cycles per op.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             c_q, c_d;
  logic             mode_q, mode_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;

  logic [DIGIT-1:0]       dig;
  logic                   dig_cout;
  logic [WIDTH+DIGIT-1:0] part_ext;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (c_q),
    .mode (mode_q),
    .d    (dig),
    .cout (dig_cout)
  );

  // New digit enters at the MSB end so the LSB digit ends up at bit 0 after N shifts.
  assign part_ext = {dig, part_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    c_d      = c_q;
    mode_d   = mode_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    result_d = result_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          c_d     = bin;
          mode_d  = mode;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          part_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        part_d = part_ext[WIDTH+DIGIT-1:DIGIT];
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        c_d    = dig_cout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = part_ext[WIDTH+DIGIT-1:DIGIT];
          bout_d   = dig_cout;
          ovf_d    = ovf_calc(mode_q, amsb_q, bmsb_q, part_ext[WIDTH+DIGIT-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      c_q      <= 1'b0;
      mode_q   <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      result_q <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      result_q <= result_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign bout   = bout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: an 8x1 and a 16x4 instance checked
// against an integer-arithmetic reference model.
module tb_serial_addsub;

  typedef struct {
    logic [15:0] r;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s_start = 0, s_mode = 0, s_bin = 0;
  logic [7:0] s_a = 0, s_b = 0;
  logic       s_busy, s_done, s_bout, s_ovf;
  logic [7:0] s_result;

  logic        w_start = 0, w_mode = 0, w_bin = 0;
  logic [15:0] w_a = 0, w_b = 0;
  logic        w_busy, w_done, w_bout, w_ovf;
  logic [15:0] w_result;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .a(s_a), .b(s_b),
    .bin(s_bin), .busy(s_busy), .done(s_done), .result(s_result),
    .bout(s_bout), .ovf(s_ovf));

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(w_start), .mode(w_mode), .a(w_a), .b(w_b),
    .bin(w_bin), .busy(w_busy), .done(w_done), .result(w_result),
    .bout(w_bout), .ovf(w_ovf));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  exp_t q8[$];
  exp_t q16[$];
  int nd[2] = '{8, 4};
  int busy_cnt[2] = '{0, 0};
  int last_done[2] = '{0, 0};
  int prev_done[2] = '{0, 0};
  logic [15:0] prev_res[2];
  logic prev_bo[2], prev_ov[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic at width w.
  function automatic exp_t model(input int w, input bit m, input int a, input int b, input bit bin);
    exp_t e;
    int md, full, sa, sb, sres;
    md = 1 << w;
    sa = (a >= md / 2) ? a - md : a;
    sb = (b >= md / 2) ? b - md : b;
    if (m) begin
      full = a + b + int'(bin);
      e.bo = (full >= md);
      sres = sa + sb + int'(bin);
    end else begin
      full = a - b - int'(bin);
      e.bo = (full < 0);
      sres = sa - sb - int'(bin);
    end
    e.r  = 16'(((full % md) + md) % md);
    e.ov = (sres < -(md / 2)) || (sres > (md / 2) - 1);
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] r, input logic bo, input logic ov);
    exp_t e;
    e.r = r; e.bo = bo; e.ov = ov; e.acc = 0;
    return e;
  endfunction

  task automatic mon(input int sel, input logic done, input logic busy,
                     input logic [15:0] res, input logic bo, input logic ov);
    exp_t e;
    string p;
    p = (sel == 0) ? "w8" : "w16";
    if (rst) begin
      busy_cnt[sel] = 0;
    end else begin
      if (busy) busy_cnt[sel]++;
      if (done) begin
        if ((sel == 0 && q8.size() == 0) || (sel == 1 && q16.size() == 0)) begin
          chk({p, " unexpected done"}, 1, 0);
        end else begin
          e = (sel == 0) ? q8.pop_front() : q16.pop_front();
          chk({p, " result"}, 32'(res), 32'(e.r));
          chk({p, " bout"}, 32'(bo), 32'(e.bo));
          chk({p, " ovf"}, 32'(ov), 32'(e.ov));
          chk({p, " latency"}, 32'(cyc - e.acc), 32'(nd[sel]));
          chk({p, " busy cycles"}, 32'(busy_cnt[sel]), 32'(nd[sel]));
        end
        busy_cnt[sel] = 0;
        prev_done[sel] = last_done[sel];
        last_done[sel] = cyc;
      end else begin
        chk({p, " outputs stable"}, {14'b0, bo, ov, res}, {14'b0, prev_bo[sel], prev_ov[sel], prev_res[sel]});
      end
    end
    prev_res[sel] = res;
    prev_bo[sel] = bo;
    prev_ov[sel] = ov;
  endtask

  always @(negedge clk) begin
    mon(0, s_done, s_busy, {8'b0, s_result}, s_bout, s_ovf);
    mon(1, w_done, w_busy, w_result, w_bout, w_ovf);
  end

  // Called and returns at a negedge. Inputs are scrambled after accept to prove latching.
  task automatic issue(input int sel, input bit m, input logic [15:0] a, input logic [15:0] b,
                       input bit bin, input exp_t e, input bit push);
    int n = 0;
    while (((sel == 0) ? s_busy : w_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait not busy", 1, 0);
    if (sel == 0) begin
      s_mode = m; s_a = a[7:0]; s_b = b[7:0]; s_bin = bin; s_start = 1;
    end else begin
      w_mode = m; w_a = a; w_b = b; w_bin = bin; w_start = 1;
    end
    @(negedge clk);
    s_start = 0; w_start = 0;
    s_a = 8'($urandom); s_b = 8'($urandom); s_mode = 1'($urandom); s_bin = 1'($urandom);
    w_a = 16'($urandom); w_b = 16'($urandom); w_mode = 1'($urandom); w_bin = 1'($urandom);
    e.acc = cyc;
    if (push) begin
      if (sel == 0) q8.push_back(e);
      else q16.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain timeout", 1, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    bit rm, rbin;
    repeat (3) @(negedge clk);
    chk("reset w8", {s_busy, s_done, s_bout, s_ovf, s_result}, 12'h000);
    chk("reset w16", {w_busy, w_done, w_bout, w_ovf, w_result}, 20'h00000);
    rst = 0;
    @(negedge clk);

    issue(0, 0, 16'h05, 16'h03, 0, mk(16'h02, 0, 0), 1);
    issue(0, 0, 16'h03, 16'h05, 0, mk(16'hFE, 1, 0), 1);
    issue(0, 0, 16'h80, 16'h01, 0, mk(16'h7F, 0, 1), 1);
    issue(0, 1, 16'h7F, 16'h01, 0, mk(16'h80, 0, 1), 1);
    issue(0, 1, 16'hFF, 16'h00, 1, mk(16'h00, 1, 0), 1);
    issue(1, 0, 16'h1234, 16'h4321, 0, mk(16'hCF13, 1, 0), 1);
    drain();
    chk("back-to-back gap", 32'(last_done[0] - prev_done[0]), 32'd9);

    // start pulsed mid-RUN must be ignored
    repeat (2) @(negedge clk);
    issue(0, 0, 16'h40, 16'h11, 0, mk(16'h2F, 0, 0), 1);
    repeat (3) @(negedge clk);
    s_mode = 1; s_a = 8'hAA; s_b = 8'h55; s_bin = 1; s_start = 1;
    @(negedge clk);
    s_start = 0;
    drain();
    repeat (12) @(negedge clk);
    chk("ignored start no extra op", 32'(s_busy), 0);

    // reset mid-run: previous result 0x2F must clear, no done afterwards
    issue(0, 1, 16'h7F, 16'h7F, 0, mk(16'h0, 0, 0), 0);
    repeat (2) @(negedge clk);
    chk("busy before reset", 32'(s_busy), 1);
    rst = 1;
    #1;
    chk("mid-run reset w8", {s_busy, s_done, s_bout, s_ovf, s_result}, 12'h000);
    chk("mid-run reset w16", {w_busy, w_done, w_bout, w_ovf, w_result}, 20'h00000);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    issue(0, 1, 16'h7F, 16'h7F, 0, mk(16'hFE, 0, 1), 1);
    drain();

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
      rm = 1'($urandom); rbin = 1'($urandom);
      issue(0, rm, ra, rb, rbin, model(8, rm, int'(ra), int'(rb), rbin), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rm = 1'($urandom); rbin = 1'($urandom);
      issue(1, rm, ra, rb, rbin, model(16, rm, int'(ra), int'(rb), rbin), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
